// File: rtl/vga_scene_scanner_pkg.sv
// Shared 640x480@60 timing, colour and scene-size constants for the VGA scene scanner.
// The VGA_SCANNER_GRID_EN macro is consumed by vga_scene_scanner.sv.
package vga_scene_scanner_pkg;

    localparam int scene_width_p  = 10;
    localparam int scene_height_p = 20;

    localparam logic [9:0] H_VIS  = 10'd640;
    localparam logic [9:0] H_FP   = 10'd16;
    localparam logic [9:0] H_SYNC = 10'd96;
    localparam logic [9:0] H_BP   = 10'd48;
    localparam logic [9:0] H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

    localparam logic [9:0] V_VIS  = 10'd480;
    localparam logic [9:0] V_FP   = 10'd10;
    localparam logic [9:0] V_SYNC = 10'd2;
    localparam logic [9:0] V_BP   = 10'd33;
    localparam logic [9:0] V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_SYNC_S = H_VIS + H_FP;
    localparam logic [9:0] H_SYNC_E = H_SYNC_S + H_SYNC;
    localparam logic [9:0] V_SYNC_S = V_VIS + V_FP;
    localparam logic [9:0] V_SYNC_E = V_SYNC_S + V_SYNC;

    localparam logic [11:0] COL_BLANK = 12'h000;
    localparam logic [11:0] COL_CM    = 12'h0FF;
    localparam logic [11:0] COL_MM    = 12'hFFF;
    localparam logic [11:0] COL_LOSE  = 12'hF00;
    localparam logic [11:0] COL_EMPTY = 12'h111;
    localparam logic [11:0] COL_GRID  = 12'h333;
    localparam logic [11:0] COL_NEXT  = 12'hFF0;

    typedef struct packed {
        logic vis;
        logic field;
        logic next;
        logic hs;
        logic vs;
        logic pbit;
        logic grid;
    } s1_t;

    localparam s1_t S1_RST = '{vis: 1'b0, field: 1'b0, next: 1'b0,
                               hs: 1'b1, vs: 1'b1, pbit: 1'b0,
                               grid: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// 640x480@60 horizontal/vertical counters with sync levels, visible flag
// and a registered frame-start pulse.
module vga_timing_gen
    import vga_scene_scanner_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hs,
    output logic       vs,
    output logic       vis,
    output logic       frame_start
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
            if (h_cnt == H_TOT - 10'd1) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_TOT - 10'd1) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign hs  = !((h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E));
    assign vs  = !((v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E));
    assign vis = (h_cnt < H_VIS) && (v_cnt < V_VIS);

endmodule

// File: rtl/vga_scene_scanner.sv
// VGA scanner: fetches playfield cells from the game logic, renders field and
// next-block preview. Define VGA_SCANNER_GRID_EN to draw a 1-px cell grid.
module vga_scene_scanner
    import vga_scene_scanner_pkg::*;
#(
    parameter int width_p    = scene_width_p,
    parameter int height_p   = scene_height_p,
    parameter int cell_px_p  = 16,
    parameter int field_x0_p = 240,
    parameter int field_y0_p = 80,
    parameter int next_x0_p  = 432,
    parameter int next_y0_p  = 80
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    output logic [$clog2(width_p)-1:0]  dis_logic_x_o,
    output logic [$clog2(height_p)-1:0] dis_logic_y_o,
    input  logic                        dis_logic_mm_i,
    input  logic                        dis_logic_cm_i,
    input  logic [3:0][3:0]             dis_logic_next_block_i,
    input  logic                        lose_i,
    output logic                        hsync_o,
    output logic                        vsync_o,
    output logic [11:0]                 rgb_o,
    output logic                        frame_start_o
);

    localparam int CS = $clog2(cell_px_p);
    localparam int XW = $clog2(width_p);
    localparam int YW = $clog2(height_p);

    localparam logic [9:0] FX0 = 10'(field_x0_p);
    localparam logic [9:0] FX1 = 10'(field_x0_p + width_p * cell_px_p);
    localparam logic [9:0] FY0 = 10'(field_y0_p);
    localparam logic [9:0] FY1 = 10'(field_y0_p + height_p * cell_px_p);
    localparam logic [9:0] NX0 = 10'(next_x0_p);
    localparam logic [9:0] NX1 = 10'(next_x0_p + 4 * cell_px_p);
    localparam logic [9:0] NY0 = 10'(next_y0_p);
    localparam logic [9:0] NY1 = 10'(next_y0_p + 4 * cell_px_p);
    localparam logic [9:0] XMAX = 10'(width_p - 1);
    localparam logic [9:0] YMAX = 10'(height_p - 1);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       hs;
    logic       vs;
    logic       vis;

    vga_timing_gen u_timing (
        .clk         (clk_i),
        .rst_n       (reset_n_i),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hs          (hs),
        .vs          (vs),
        .vis         (vis),
        .frame_start (frame_start_o)
    );

    logic [3:0][3:0] next_q;
    logic            lose_q;

    logic [9:0] dx, dy, nx, ny;
    logic [9:0] cx, cy;
    logic [1:0] pr, pc;
    logic       in_field;
    logic       in_next;
    s1_t        s1_d;
    s1_t        s1_q;

    always_comb begin
        dx = h_cnt - FX0;
        dy = v_cnt - FY0;
        nx = h_cnt - NX0;
        ny = v_cnt - NY0;
        in_field = (h_cnt >= FX0) && (h_cnt < FX1) &&
                   (v_cnt >= FY0) && (v_cnt < FY1);
        in_next  = (h_cnt >= NX0) && (h_cnt < NX1) &&
                   (v_cnt >= NY0) && (v_cnt < NY1);
        // Cell sizes are powers of two, so indexing is a shift.
        cx = dx >> CS;
        cy = dy >> CS;
        if (cx > XMAX) cx = XMAX;
        if (cy > YMAX) cy = YMAX;
        pr = 2'(ny >> CS);
        pc = 2'(nx >> CS);
        s1_d       = S1_RST;
        s1_d.vis   = vis;
        s1_d.field = in_field;
        s1_d.next  = in_next;
        s1_d.hs    = hs;
        s1_d.vs    = vs;
        s1_d.pbit  = in_next && next_q[pr][pc];
`ifdef VGA_SCANNER_GRID_EN
        s1_d.grid  = (dx[CS-1:0] == '0) || (dy[CS-1:0] == '0);
`else
        s1_d.grid  = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dis_logic_x_o <= '0;
            dis_logic_y_o <= '0;
            s1_q          <= S1_RST;
        end else begin
            dis_logic_x_o <= in_field ? XW'(cx) : '0;
            dis_logic_y_o <= in_field ? YW'(cy) : '0;
            s1_q          <= s1_d;
        end
    end

    // Preview and lose are sampled on the first blank line so a frame never tears.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            next_q <= '0;
            lose_q <= 1'b0;
        end else if ((h_cnt == 10'd0) && (v_cnt == V_VIS)) begin
            next_q <= dis_logic_next_block_i;
            lose_q <= lose_i;
        end
    end

    logic [11:0] rgb_d;

    always_comb begin
        rgb_d = COL_BLANK;
        if (s1_q.vis) begin
            if (s1_q.field) begin
                if (dis_logic_cm_i)      rgb_d = COL_CM;
                else if (dis_logic_mm_i) rgb_d = lose_q ? COL_LOSE : COL_MM;
                else if (s1_q.grid)      rgb_d = COL_GRID;
                else                     rgb_d = COL_EMPTY;
            end else if (s1_q.next && s1_q.pbit) begin
                rgb_d = COL_NEXT;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rgb_o   <= COL_BLANK;
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
        end else begin
            rgb_o   <= rgb_d;
            hsync_o <= s1_q.hs;
            vsync_o <= s1_q.vs;
        end
    end

endmodule
